// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the iterative ALU.
//   - CTRL_W, op-code constants, FSM state encoding, multi-cycle op decode.
//   - Optional iterative MUL/DIVU/REMU datapath is enabled by ALU_ITER_MULDIV_EN.
package alu_pkg;

    localparam int unsigned CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_AND  = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] ALU_OR   = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] ALU_ADD  = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] ALU_MUL  = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] ALU_DIVU = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] ALU_REMU = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] ALU_SUB  = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] ALU_SLT  = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] ALU_SLTU = CTRL_W'(8);
    localparam logic [CTRL_W-1:0] ALU_NOR  = CTRL_W'(12);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Op codes that use the iterative datapath
    function automatic logic is_multi(input logic [CTRL_W-1:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_iter_if.sv
// alu_iter_if: start/done handshake bundle between the EX-stage control and alu_iter.
//   master: drives start_i, src1_i, src2_i, ctrl_i; observes busy_o, done_o, result_o, zero_o, ovf_o
//   slave : the ALU side of the same signals
interface alu_iter_if #(
    parameter int unsigned WIDTH = 32
);
    import alu_pkg::*;

    logic              start_i;
    logic [WIDTH-1:0]  src1_i;
    logic [WIDTH-1:0]  src2_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic              busy_o;
    logic              done_o;
    logic [WIDTH-1:0]  result_o;
    logic              zero_o;
    logic              ovf_o;

    modport master (
        output start_i, src1_i, src2_i, ctrl_i,
        input  busy_o, done_o, result_o, zero_o, ovf_o
    );

    modport slave (
        input  start_i, src1_i, src2_i, ctrl_i,
        output busy_o, done_o, result_o, zero_o, ovf_o
    );

endinterface

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative unsigned shift-add multiplier / restoring divider.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : capture a_i/b_i/div_i and load the step counter with WIDTH
//   div_i        : 1 = divide (DIVU/REMU), 0 = multiply
//   a_i, b_i     : operands (multiplicand/multiplier or dividend/divisor)
//   last_c       : current step is the final one (counter == 1)
//   prod_o, quot_o, rem_o : registered low product, quotient, remainder
module alu_muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_c,
    output logic [WIDTH-1:0] prod_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    // a: multiplicand (shifts left) or dividend/quotient; b: multiplier or divisor;
    // acc: product accumulator or partial remainder
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             div_q, div_d;
    logic [WIDTH:0]   rshift;
    logic [WIDTH:0]   trial;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            div_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            div_q <= div_d;
        end
    end

    // One iteration step per cycle while the counter is non-zero
    always_comb begin
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        div_d  = div_q;
        rshift = {acc_q, a_q[WIDTH-1]};
        trial  = rshift - {1'b0, b_q};
        if (load_i) begin
            cnt_d = CNT_W'(WIDTH);
            a_d   = a_i;
            b_d   = b_i;
            acc_d = '0;
            div_d = div_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (div_q) begin
                // Restoring step; divisor 0 always "fits", giving all-ones quotient, rem = dividend
                if (!trial[WIDTH]) begin
                    acc_d = trial[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rshift[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (b_q[0]) begin
                    acc_d = acc_q + a_q;
                end
                a_d = {a_q[WIDTH-2:0], 1'b0};
                b_d = {1'b0, b_q[WIDTH-1:1]};
            end
        end
    end

    assign last_c = (cnt_q == CNT_W'(1));
    assign prod_o = acc_q;
    assign quot_o = a_q;
    assign rem_o  = acc_q;

endmodule

// File: rtl/alu_iter.sv
// alu_iter: registered EX-stage ALU with start/done handshake.
//   clk_i : rising-edge clock
//   rst_i : synchronous active-high reset (aborts any operation, no done_o)
//   bus   : alu_iter_if.slave (start_i, src1_i, src2_i, ctrl_i / busy_o, done_o,
//           result_o, zero_o, ovf_o)
// Single-cycle ops register their result on the accepting edge. With
// ALU_ITER_MULDIV_EN defined, MUL/DIVU/REMU run WIDTH iterations then FIN;
// otherwise they behave as unknown codes and busy_o is tied low.
module alu_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic      clk_i,
    input  logic      rst_i,
    alu_iter_if.slave bus
);

    state_e           state_q, state_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] sc_result;
    logic             sc_ovf;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic             accept_c;

    assign accept_c = (state_q == ST_IDLE) && bus.start_i;

`ifdef ALU_ITER_MULDIV_EN
    logic              busy_q, busy_d;
    logic [CTRL_W-1:0] op_q, op_d;
    logic              load_c;
    logic              last_c;
    logic [WIDTH-1:0]  md_prod, md_quot, md_rem;
    logic [WIDTH-1:0]  md_result;

    assign load_c = accept_c && is_multi(bus.ctrl_i);

    alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (load_c),
        .div_i  (bus.ctrl_i != ALU_MUL),
        .a_i    (bus.src1_i),
        .b_i    (bus.src2_i),
        .last_c (last_c),
        .prod_o (md_prod),
        .quot_o (md_quot),
        .rem_o  (md_rem)
    );

    always_comb begin
        case (op_q)
            ALU_MUL:  md_result = md_prod;
            ALU_DIVU: md_result = md_quot;
            default:  md_result = md_rem;
        endcase
    end

    assign bus.busy_o = busy_q;
`else
    assign bus.busy_o = 1'b0;
`endif

    // Single-cycle result and ADD/SUB overflow
    always_comb begin
        sum       = bus.src1_i + bus.src2_i;
        dif       = bus.src1_i - bus.src2_i;
        sc_result = '0;
        sc_ovf    = 1'b0;
        case (bus.ctrl_i)
            ALU_AND:  sc_result = bus.src1_i & bus.src2_i;
            ALU_OR:   sc_result = bus.src1_i | bus.src2_i;
            ALU_ADD: begin
                sc_result = sum;
                sc_ovf    = (bus.src1_i[WIDTH-1] == bus.src2_i[WIDTH-1]) &&
                            (sum[WIDTH-1] != bus.src1_i[WIDTH-1]);
            end
            ALU_SUB: begin
                sc_result = dif;
                sc_ovf    = (bus.src1_i[WIDTH-1] != bus.src2_i[WIDTH-1]) &&
                            (dif[WIDTH-1] != bus.src1_i[WIDTH-1]);
            end
            ALU_SLT:  sc_result = WIDTH'($signed(bus.src1_i) < $signed(bus.src2_i));
            ALU_SLTU: sc_result = WIDTH'(bus.src1_i < bus.src2_i);
            ALU_NOR:  sc_result = ~(bus.src1_i | bus.src2_i);
            default:  sc_result = '0;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
`ifdef ALU_ITER_MULDIV_EN
            busy_q   <= 1'b0;
            op_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
`ifdef ALU_ITER_MULDIV_EN
            busy_q   <= busy_d;
            op_q     <= op_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
`ifdef ALU_ITER_MULDIV_EN
        case (state_q)
            ST_IDLE: if (load_c) state_d = ST_RUN;
            ST_RUN:  if (last_c) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
`else
        state_d = ST_IDLE;
`endif
    end

    // Registered-output next values
    always_comb begin
        done_d   = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
`ifdef ALU_ITER_MULDIV_EN
        busy_d   = (state_d != ST_IDLE);
        op_d     = load_c ? bus.ctrl_i : op_q;
        if (state_q == ST_FIN) begin
            done_d   = 1'b1;
            result_d = md_result;
            zero_d   = (md_result == '0);
            ovf_d    = 1'b0;
        end else if (accept_c && !load_c) begin
`else
        if (accept_c) begin
`endif
            done_d   = 1'b1;
            result_d = sc_result;
            zero_d   = (sc_result == '0);
            ovf_d    = sc_ovf;
        end
    end

    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
    assign bus.zero_o   = zero_q;
    assign bus.ovf_o    = ovf_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed self-checking bench for alu_iter (WIDTH=32).
// Multi-cycle checks apply when ALU_ITER_MULDIV_EN is defined; otherwise
// codes 3/4/5 are expected to act as unknown single-cycle codes.
module tb_alu_iter;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   k;
    logic saw_done;

    alu_iter_if #(.WIDTH(W)) bus ();

    alu_iter #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a start for one edge; returns #1 after the accepting edge
    task automatic issue(input logic [CTRL_W-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start_i = 1'b1;
        bus.ctrl_i  = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic single(input logic [CTRL_W-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input logic exp_ovf, input string tag);
        issue(op, a, b);
        check({tag, "_done"}, W'(bus.done_o), W'(1));
        check({tag, "_res"},  bus.result_o, exp);
        check({tag, "_zero"}, W'(bus.zero_o), W'(exp == '0));
        check({tag, "_ovf"},  W'(bus.ovf_o), W'(exp_ovf));
        tick();
        check({tag, "_pulse"}, W'(bus.done_o), W'(0));
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

`ifdef ALU_ITER_MULDIV_EN
    task automatic multi(input logic [CTRL_W-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input string tag);
        int n;
        issue(op, a, b);
        check({tag, "_busy"}, W'(bus.busy_o), W'(1));
        wait_done(n);
        check({tag, "_lat"}, W'(n), W'(W + 1));
        check({tag, "_res"}, bus.result_o, exp);
        check({tag, "_idle"}, W'(bus.busy_o), W'(0));
        check({tag, "_ovf"}, W'(bus.ovf_o), W'(0));
    endtask
`endif

    initial begin
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.ctrl_i  = '0;
        bus.src1_i  = '0;
        bus.src2_i  = '0;
        tick();
        tick();
        check("rst_busy", W'(bus.busy_o), W'(0));
        check("rst_done", W'(bus.done_o), W'(0));
        check("rst_res",  bus.result_o, 32'h0);
        check("rst_zero", W'(bus.zero_o), W'(1));
        check("rst_ovf",  W'(bus.ovf_o), W'(0));
        rst = 1'b0;
        tick();

        // Single-cycle ops
        single(ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, "add_ovf");
        single(ALU_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, "sub_zero");
        single(ALU_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, "sub_ovf");
        single(ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, "and");
        single(ALU_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, "or");
        single(ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, "slt");
        single(ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, "sltu");
        single(ALU_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "nor");
        single(4'd9,     32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b0, "unk9");

`ifdef ALU_ITER_MULDIV_EN
        // MUL with an ignored start pulse while busy
        issue(ALU_MUL, 32'h0001_0000, 32'h0001_0001);
        check("mul_busy_first", W'(bus.busy_o), W'(1));
        k = 0;
        while (bus.done_o !== 1'b1 && k < 100) begin
            if (k == 5) begin
                bus.start_i = 1'b1;
                bus.ctrl_i  = ALU_ADD;
                bus.src1_i  = 32'h0000_0001;
                bus.src2_i  = 32'h0000_0001;
            end
            tick();
            bus.start_i = 1'b0;
            k++;
            if (k == W) check("mul_busy_last", W'(bus.busy_o), W'(1));
        end
        check("mul_lat",  W'(k), W'(W + 1));
        check("mul_res",  bus.result_o, 32'h0001_0000);
        check("mul_zero", W'(bus.zero_o), W'(0));
        check("mul_idle", W'(bus.busy_o), W'(0));

        // Back-to-back: ADD launched during the MUL done_o cycle
        single(ALU_ADD, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, "b2b_add");

        multi(ALU_DIVU, 32'd100, 32'd7, 32'd14, "divu");
        multi(ALU_REMU, 32'd100, 32'd7, 32'd2,  "remu");
        multi(ALU_DIVU, 32'd9,   32'd0, 32'hFFFF_FFFF, "divu_z");
        multi(ALU_REMU, 32'd9,   32'd0, 32'd9,  "remu_z");

        // Reset in the middle of a MUL
        issue(ALU_MUL, 32'h0000_0003, 32'h0000_0005);
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        check("mrst_busy", W'(bus.busy_o), W'(0));
        check("mrst_done", W'(bus.done_o), W'(0));
        check("mrst_res",  bus.result_o, 32'h0);
        check("mrst_zero", W'(bus.zero_o), W'(1));
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done_o !== 1'b0) saw_done = 1'b1;
        end
        check("mrst_nodone", W'(saw_done), W'(0));
        single(ALU_ADD, 32'd3, 32'd4, 32'd7, 1'b0, "post_rst_add");
`else
        single(ALU_MUL,  32'h0001_0000, 32'h0001_0001, 32'h0, 1'b0, "mul_off");
        check("mul_off_busy", W'(bus.busy_o), W'(0));
        single(ALU_DIVU, 32'd100, 32'd7, 32'h0, 1'b0, "divu_off");
        single(ALU_REMU, 32'd100, 32'd7, 32'h0, 1'b0, "remu_off");

        // Reset right after a result: values return to reset state
        issue(ALU_ADD, 32'd1, 32'd1);
        rst = 1'b1;
        tick();
        check("srst_done", W'(bus.done_o), W'(0));
        check("srst_res",  bus.result_o, 32'h0);
        check("srst_zero", W'(bus.zero_o), W'(1));
        rst = 1'b0;
        tick();
        single(ALU_ADD, 32'd3, 32'd4, 32'd7, 1'b0, "post_rst_add");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU.
- Keeps the existing logic/arithmetic op codes at one-cycle latency, and adds signed/unsigned compare, iterative unsigned multiply, divide and remainder.
- Uses a start/done handshake so the multi-cycle CPU control unit can stall on long operations.
- Sits in the EX stage between the register-file read mux and the write-back mux.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CTRL_W, 4, op-code width.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk_i  input  1  rising-edge clock
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  launch operation; sampled only when busy_o=0
- src1_i  input  WIDTH  operand A, captured on accepted start
- src2_i  input  WIDTH  operand B, captured on accepted start
- ctrl_i  input  CTRL_W  op code, captured on accepted start
- busy_o  output  1  operation in flight; start_i ignored
- done_o  output  1  one-cycle pulse, result valid
- result_o  output  WIDTH  registered result, held until the next done_o
- zero_o  output  1  registered (result==0), updated with result_o
- ovf_o  output  1  signed overflow for ADD/SUB, else 0

Behaviour:
- Op codes:
  - 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (signed), 8 SLTU, 12 NOR: single-cycle.
  - 3 MUL (low WIDTH bits of unsigned product), 4 DIVU (quotient), 5 REMU (remainder): multi-cycle.
  - Any other code: result 0, single-cycle.
- Reset: state IDLE; busy_o=0, done_o=0, result_o=0, zero_o=1, ovf_o=0; counter=0.
- FSM states are IDLE, RUN, FIN.
  - IDLE: on start_i with a single-cycle op, compute and register the result; done_o=1 next cycle; remain IDLE.
    - Latency: start at edge N, done_o and result at edge N+1.
  - IDLE: on start_i with a multi-cycle op, latch operands, load counter with WIDTH, assert busy_o, go to RUN.
  - RUN: one shift-add (MUL) or one restoring-subtract (DIVU/REMU) step per cycle; counter decrements. When it reaches 1, the step completes and the FSM moves to FIN.
  - FIN: register the result, pulse done_o, clear busy_o, go to IDLE.
    - Latency: start at edge N, done_o at edge N+WIDTH+1.
- start_i while busy_o=1: ignored, with no effect on the operation in flight.
- start_i in the same cycle as done_o: accepted (the FSM is in IDLE or FIN->IDLE; FIN counts as busy, so a start during FIN is ignored).
- Divide by zero: quotient = all ones; remainder = src1. Still takes the full WIDTH+1 cycles; ovf_o=0.
- ADD/SUB overflow: set when the operand signs imply the opposite result sign; ovf_o is cleared for all other ops.
- SLT compares the two operands as two's-complement signed values; SLTU compares them unsigned.
- rst_i mid-operation: abort, return to the reset values next edge, and emit no done_o.
- result_o/zero_o change only on a done_o cycle.

Optional Feature:
- Macro ALU_ITER_MULDIV_EN.
- Defined: codes 3/4/5 run iteratively as described above.
- Undefined:
  - The multi-cycle datapath and RUN/FIN states are not compiled.
  - Codes 3/4/5 behave as unknown codes: result 0, single-cycle, done at N+1.
  - busy_o is tied to 0.

Decomposition:
- Package alu_pkg holds:
  - Op-code localparams (ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_MUL=3, ALU_DIVU=4, ALU_REMU=5, ALU_SUB=6, ALU_SLT=7, ALU_SLTU=8, ALU_NOR=12).
  - The FSM state encoding.
  - CTRL_W.
- Sub-module alu_muldiv_seq holds the iterative multiply/divide datapath and counter.
  - Inputs: load, op, a, b.
  - Outputs: last, product/quotient/remainder.
  - Instantiated only under ALU_ITER_MULDIV_EN.

Test Plan:
- WIDTH=32. ADD 0x7FFFFFFF+1 -> done at N+1, result 0x80000000, ovf_o=1, zero_o=0. SUB 5-5 -> result 0, zero_o=1, ovf_o=0.
- SLT -1 vs 1 -> 1; SLTU 0xFFFFFFFF vs 1 -> 0; NOR 0,0 -> 0xFFFFFFFF; ctrl 9 -> 0 at N+1.
- MUL 0x10000 * 0x10001 -> result 0x00010000 (low bits), busy_o high for cycles N+1..N+32, done at N+33. A start_i pulse during busy is ignored and the result is unchanged.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9. Each completes in 33 cycles.
- Assert rst_i at cycle 10 of a MUL -> next edge busy_o=0, result_o=0, zero_o=1, no done_o. A new ADD 3+4 afterwards -> 7 at N+1.
- Back-to-back: ADD issued in the cycle after a MUL's done_o -> ADD done one cycle later; the MUL result was visible during its done_o cycle.
